// File: rtl/add_sub_serial.sv
// rtl/add_sub_serial.sv - multi-cycle N-bit adder/subtractor, D bits per clock, start/busy/done handshake.
// Optional ADD_SAT_EN: signed saturation of the N-bit result on overflow.
module add_sub_serial #(
    parameter int N = 16,
    parameter int D = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sub,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N:0]   out,
    output logic         c_out,
    output logic         ovf
);
    localparam int S  = (D >= 1) ? N / D : 1;
    localparam int CW = (S > 1) ? $clog2(S) : 1;
    localparam logic [N-1:0] SAT_MIN = N'(1) << (N - 1);
    localparam logic [N-1:0] SAT_MAX = ~SAT_MIN;

    generate
        if (D < 1 || D > N || (N % D) != 0) begin : g_bad_params
            $error("add_sub_serial: D must satisfy 1 <= D <= N and divide N");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          carry_q, carry_d;
    logic          busy_q, busy_d, done_q, done_d;
    logic [N:0]    out_q, out_d;
    logic          c_out_q, c_out_d, ovf_q, ovf_d;

    logic [D:0]    slice;
    logic [N-1:0]  sum_next, sum_fin;
    logic          ovf_calc;

    // Operands shift right each slice, so the active slice is always the low D bits
    // and the operand sign bits sit at bit D-1 during the final slice.
    always_comb begin
        slice    = {1'b0, a_q[D-1:0]} + {1'b0, b_q[D-1:0]} + (D+1)'(carry_q);
        sum_next = (sum_q >> D) | (N'(slice[D-1:0]) << (N - D));
        ovf_calc = (a_q[D-1] == b_q[D-1]) && (sum_next[N-1] != a_q[D-1]);
        sum_fin  = sum_next;
`ifdef ADD_SAT_EN
        if (ovf_calc) begin
            sum_fin = a_q[D-1] ? SAT_MIN : SAT_MAX;
        end
`endif

        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        busy_d  = busy_q;
        done_d  = done_q;
        out_d   = out_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE, DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
                if (start) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    a_d     = a;
                    b_d     = b ^ {N{sub}};
                    carry_d = sub;
                    cnt_d   = '0;
                    sum_d   = '0;
                end
            end
            RUN: begin
                a_d     = a_q >> D;
                b_d     = b_q >> D;
                carry_d = slice[D];
                sum_d   = sum_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(S - 1)) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    out_d   = {slice[D], sum_fin};
                    c_out_d = slice[D];
                    ovf_d   = ovf_calc;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign out   = out_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;
endmodule

// File: tb/tb_add_sub_serial.sv
// tb/tb_add_sub_serial.sv - randomized/directed bench for add_sub_serial at D=4, D=16 and D=1 (N=16).
module tb_add_sub_serial;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        sub;
    logic        start_v [3];
    logic        busy_v  [3];
    logic        done_v  [3];
    logic        c_v     [3];
    logic        ovf_v   [3];
    logic [16:0] out_v   [3];
    int          s_of    [3] = '{4, 1, 16};
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    add_sub_serial #(.N(16), .D(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .sub(sub), .a(a), .b(b),
        .busy(busy_v[0]), .done(done_v[0]), .out(out_v[0]), .c_out(c_v[0]), .ovf(ovf_v[0]));
    add_sub_serial #(.N(16), .D(16)) u_d16 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .sub(sub), .a(a), .b(b),
        .busy(busy_v[1]), .done(done_v[1]), .out(out_v[1]), .c_out(c_v[1]), .ovf(ovf_v[1]));
    add_sub_serial #(.N(16), .D(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .sub(sub), .a(a), .b(b),
        .busy(busy_v[2]), .done(done_v[2]), .out(out_v[2]), .c_out(c_v[2]), .ovf(ovf_v[2]));

    // Reference: integer arithmetic on the operand values, signed range check for overflow.
    function automatic void model(input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                                  output logic [16:0] eo, output logic eov);
        longint ua, ub, full, sa, sb, r;
        ua   = longint'(ia);
        ub   = longint'(ib);
        full = isub ? ua + ((~ub) & 64'hFFFF) + 1 : ua + ub;
        sa   = (ua >= 32768) ? ua - 65536 : ua;
        sb   = (ub >= 32768) ? ub - 65536 : ub;
        r    = isub ? sa - sb : sa + sb;
        eov  = (r > 32767) || (r < -32768);
        eo   = full[16:0];
`ifdef ADD_SAT_EN
        if (eov) eo[15:0] = (r > 32767) ? 16'h7FFF : 16'h8000;
`endif
    endfunction

    task automatic do_op(input int w, input logic [15:0] ia, input logic [15:0] ib, input logic isub,
                         output int lat, output int busy_cnt, output logic [16:0] o,
                         output logic co, output logic ov, output int extra_done);
        @(negedge clk);
        a = ia; b = ib; sub = isub; start_v[w] = 1'b1;
        @(negedge clk);
        start_v[w] = 1'b0;
        a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
        lat = 0; busy_cnt = 0;
        while (!done_v[w] && lat < 200) begin
            if (busy_v[w]) busy_cnt++;
            @(negedge clk);
            lat++;
        end
        if (lat >= 200) lat = -1;
        o = out_v[w]; co = c_v[w]; ov = ovf_v[w];
        extra_done = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done_v[w]) extra_done++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #12;
        for (int w = 0; w < 3; w++) begin
            checks++;
            if ({busy_v[w], done_v[w], out_v[w], c_v[w], ovf_v[w]} !== 21'd0) begin
                failures++;
                $display("FAIL reset_outputs inst=%0d got busy=%b done=%b out=%h c=%b ovf=%b want all 0",
                         w, busy_v[w], done_v[w], out_v[w], c_v[w], ovf_v[w]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_op(input string name, input int w, input logic [15:0] ia,
                            input logic [15:0] ib, input logic isub);
        int lat, bc, xd;
        logic [16:0] o, eo;
        logic co, ov, eov;
        do_op(w, ia, ib, isub, lat, bc, o, co, ov, xd);
        model(ia, ib, isub, eo, eov);
        checks++;
        if (o !== eo || co !== eo[16] || ov !== eov) begin
            failures++;
            $display("FAIL %s_result inst=%0d a=%h b=%h sub=%b got out=%h c=%b ovf=%b want out=%h c=%b ovf=%b",
                     name, w, ia, ib, isub, o, co, ov, eo, eo[16], eov);
        end
        checks++;
        if (lat !== s_of[w] || bc !== s_of[w] || xd !== 0) begin
            failures++;
            $display("FAIL %s_timing inst=%0d got lat=%0d busy=%0d extra_done=%0d want lat=%0d busy=%0d extra_done=0",
                     name, w, lat, bc, xd, s_of[w], s_of[w]);
        end
    endtask

    task automatic test_directed;
        check_op("add_carry_ripple", 0, 16'h00FF, 16'h0001, 1'b0);
        check_op("add_wrap",         0, 16'hFFFF, 16'h0001, 1'b0);
        check_op("add_ovf",          0, 16'h7FFF, 16'h0001, 1'b0);
        check_op("sub_neg",          0, 16'h0005, 16'h0007, 1'b1);
        check_op("sub_ovf",          0, 16'h8000, 16'h0001, 1'b1);
        check_op("sub_zero",         0, 16'h1234, 16'h1234, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 24; i++) begin
            check_op("random", i % 3, 16'($urandom), 16'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_widths;
        check_op("width_d16", 1, 16'h00FF, 16'h0001, 1'b0);
        check_op("width_d1",  2, 16'h00FF, 16'h0001, 1'b0);
        check_op("width_d1_sub_ovf", 2, 16'h8000, 16'h0001, 1'b1);
    endtask

    task automatic test_start_while_busy;
        int lat, dn;
        logic [16:0] eo;
        logic eov;
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; sub = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; sub = 1'b1; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        lat = 2;
        while (!done_v[0] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        model(16'h1234, 16'h1111, 1'b0, eo, eov);
        checks++;
        if (lat !== 4 || out_v[0] !== eo || ovf_v[0] !== eov) begin
            failures++;
            $display("FAIL ignore_start got lat=%0d out=%h ovf=%b want lat=4 out=%h ovf=%b",
                     lat, out_v[0], ovf_v[0], 4, eo, eov);
        end
        dn = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) dn++;
        end
        checks++;
        if (dn !== 0 || out_v[0] !== eo) begin
            failures++;
            $display("FAIL ignore_start_hold got activity=%0d out=%h want activity=0 out=%h", dn, out_v[0], eo);
        end
    endtask

    task automatic test_back_to_back;
        int gap;
        logic [15:0] a2, b2;
        logic s2, eov;
        logic [16:0] eo;
        @(negedge clk);
        a = 16'($urandom); b = 16'($urandom); sub = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        gap = 0;
        while (!done_v[0] && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        a2 = 16'($urandom); b2 = 16'($urandom); s2 = 1'b1;
        a = a2; b = b2; sub = s2; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        a = 16'($urandom); b = 16'($urandom);
        gap = 1;
        while (!done_v[0] && gap < 200) begin
            @(negedge clk);
            gap++;
        end
        model(a2, b2, s2, eo, eov);
        checks++;
        if (gap !== 5 || out_v[0] !== eo || ovf_v[0] !== eov) begin
            failures++;
            $display("FAIL back_to_back got gap=%0d out=%h ovf=%b want gap=5 out=%h ovf=%b",
                     gap, out_v[0], ovf_v[0], eo, eov);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        int dn;
        @(negedge clk);
        a = 16'h7FFF; b = 16'h0001; sub = 1'b0; start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy_v[0], done_v[0], out_v[0], c_v[0], ovf_v[0]} !== 21'd0) begin
            failures++;
            $display("FAIL reset_mid_op got busy=%b done=%b out=%h c=%b ovf=%b want all 0",
                     busy_v[0], done_v[0], out_v[0], c_v[0], ovf_v[0]);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_v[0] || busy_v[0]) dn++;
        end
        checks++;
        if (dn !== 0) begin
            failures++;
            $display("FAIL reset_mid_op_no_done got activity=%0d want 0", dn);
        end
        check_op("after_reset", 0, 16'h00FF, 16'h0001, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        start_v = '{1'b0, 1'b0, 1'b0};
        a = '0; b = '0; sub = 1'b0;
        test_reset;
        test_directed;
        test_widths;
        test_random;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_op;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
